// File: rtl/riscv_ex_retire_q_if.sv
// EX-stage retire queue bus: issue side, functional-unit results, and retired result toward MEM.
interface riscv_ex_retire_q_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned N_FU  = 4,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned FU_BITS = $clog2(N_FU);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic                 flush_i;
  logic                 issue_valid_i;
  logic [FU_BITS-1:0]   issue_fu_i;
  logic                 issue_ready_o;
  logic [N_FU-1:0]      fu_done_i;
  logic [N_FU*XLEN-1:0] fu_r_i;
  logic [N_FU-1:0]      fu_ack_o;
  logic                 mem_stall_i;
  logic                 ex_valid_o;
  logic [XLEN-1:0]      ex_r_o;
  logic                 ex_stall_o;
  logic [CNT_W-1:0]     occupancy_o;
  logic                 illegal_o;

  // master: the retire queue itself; slave: the surrounding pipeline.
  modport master (
    input  flush_i, issue_valid_i, issue_fu_i, fu_done_i, fu_r_i, mem_stall_i,
    output issue_ready_o, fu_ack_o, ex_valid_o, ex_r_o, ex_stall_o, occupancy_o, illegal_o
  );

  modport slave (
    output flush_i, issue_valid_i, issue_fu_i, fu_done_i, fu_r_i, mem_stall_i,
    input  issue_ready_o, fu_ack_o, ex_valid_o, ex_r_o, ex_stall_o, occupancy_o, illegal_o
  );
endinterface

// File: rtl/riscv_ex_retire_q.sv
// In-order result collector for the EX stage: an issue-order queue of unit indices
// selects which functional unit may retire next onto a single registered result port.
module riscv_ex_retire_q #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned N_FU  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  riscv_ex_retire_q_if.master   bus
);
  localparam int unsigned FU_BITS = $clog2(N_FU);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  logic [FU_BITS-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               ex_valid_q;
  logic [XLEN-1:0]    ex_r_q;
  logic               illegal_q;

  logic [XLEN-1:0]    fu_r_arr [N_FU];
  logic [FU_BITS-1:0] head;
  logic               full, not_empty, fu_illegal, push, pop;

  for (genvar k = 0; k < N_FU; k++) begin : g_unpack
    assign fu_r_arr[k] = bus.fu_r_i[k*XLEN +: XLEN];
  end

  // An out-of-range index only exists when N_FU is not a power of two.
  if (N_FU == (1 << FU_BITS)) begin : g_pow2
    assign fu_illegal = 1'b0;
  end else begin : g_npow2
    assign fu_illegal = 32'(bus.issue_fu_i) >= N_FU;
  end

  assign head      = fifo_q[rd_ptr_q];
  assign full      = (count_q == CNT_W'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = bus.issue_valid_i & ~full & ~fu_illegal & ~bus.flush_i;
  assign pop       = not_empty & bus.fu_done_i[head] & ~bus.mem_stall_i & ~bus.flush_i;

  assign bus.fu_ack_o      = pop ? (N_FU'(1) << head) : '0;
  assign bus.issue_ready_o = ~full;
  assign bus.ex_stall_o    = bus.mem_stall_i | full;
  assign bus.occupancy_o   = count_q;
  assign bus.ex_valid_o    = ex_valid_q;
  assign bus.ex_r_o        = ex_r_q;
  assign bus.illegal_o     = illegal_q;

  // Queue storage carries no reset; entries are only read behind a non-zero count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= bus.issue_fu_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Result register freezes under MEM stall so a retired value is never dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q <= 1'b0;
      ex_r_q     <= '0;
    end else if (bus.flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (!bus.mem_stall_i) begin
      ex_valid_q <= pop;
      if (pop) ex_r_q <= fu_r_arr[head];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_q <= 1'b0;
    end else if (bus.issue_valid_i && fu_illegal) begin
      illegal_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_riscv_ex_retire_q.sv
// Bench for riscv_ex_retire_q: directed scenarios plus random traffic, all checked
// against a queue-based model of in-order retirement.
module tb_riscv_ex_retire_q;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned N_FU  = 4;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  riscv_ex_retire_q_if #(.XLEN(XLEN), .N_FU(N_FU), .DEPTH(DEPTH)) bus ();
  // Index 5 is only representable when N_FU is not a power of two.
  riscv_ex_retire_q_if #(.XLEN(XLEN), .N_FU(5), .DEPTH(DEPTH)) bus5 ();

  riscv_ex_retire_q #(.XLEN(XLEN), .N_FU(N_FU), .DEPTH(DEPTH)) dut (
    .clk_i (clk), .rst_ni(rst_n), .bus(bus)
  );
  riscv_ex_retire_q #(.XLEN(XLEN), .N_FU(5), .DEPTH(DEPTH)) dut5 (
    .clk_i (clk), .rst_ni(rst_n), .bus(bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int unsigned     mq[$];
  logic            m_valid;
  logic [XLEN-1:0] m_r;
  logic            m_ill;

  function automatic logic [N_FU-1:0] m_ack();
    if (mq.size() != 0 && bus.fu_done_i[mq[0]] && !bus.mem_stall_i && !bus.flush_i)
      return N_FU'(1) << mq[0];
    return '0;
  endfunction

  function automatic void set_r(int unsigned k, logic [XLEN-1:0] v);
    bus.fu_r_i[k*XLEN +: XLEN] = v;
  endfunction

  task automatic idle_inputs();
    bus.flush_i = 0; bus.issue_valid_i = 0; bus.issue_fu_i = '0;
    bus.fu_done_i = '0; bus.fu_r_i = '0; bus.mem_stall_i = 0;
    bus5.flush_i = 0; bus5.issue_valid_i = 0; bus5.issue_fu_i = '0;
    bus5.fu_done_i = '0; bus5.fu_r_i = '0; bus5.mem_stall_i = 0;
  endtask

  // Advance the model by one clock with the current inputs, then cross the edge.
  task automatic tick();
    int unsigned     sz = mq.size();
    logic            pop = (m_ack() != '0);
    logic [XLEN-1:0] r = '0;
    if (pop) r = bus.fu_r_i[mq[0]*XLEN +: XLEN];
    if (bus.issue_valid_i && 32'(bus.issue_fu_i) >= N_FU) m_ill = 1'b1;
    if (bus.flush_i) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (bus.issue_valid_i && 32'(bus.issue_fu_i) < N_FU && sz < DEPTH) mq.push_back(32'(bus.issue_fu_i));
      if (!bus.mem_stall_i) begin
        m_valid = pop;
        if (pop) m_r = r;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    mq.delete(); m_valid = 0; m_r = '0; m_ill = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.fu_done_i = 4'b1111;
    #1;
    n_tests++; if (bus.occupancy_o !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", bus.occupancy_o); end
    n_tests++; if (bus.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.ex_valid_o); end
    n_tests++; if (bus.ex_r_o !== 32'h0) begin n_fail++; $display("FAIL reset_r: got %h expected 0", bus.ex_r_o); end
    n_tests++; if (bus.illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", bus.illegal_o); end
    n_tests++; if (bus.issue_ready_o !== 1'b1 || bus.ex_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got ready=%b stall=%b expected 1/0", bus.issue_ready_o, bus.ex_stall_o); end
    n_tests++; if (bus.fu_ack_o !== 4'b0000) begin n_fail++; $display("FAIL empty_no_ack: got %b expected 0000", bus.fu_ack_o); end
    tick();
    bus.fu_done_i = '0;
  endtask

  task automatic test_single();
    bus.issue_valid_i = 1; bus.issue_fu_i = 2'd1;
    bus.fu_done_i = 4'b0010; set_r(1, 32'hDEADBEEF);
    #1;
    n_tests++; if (bus.fu_ack_o !== 4'b0000) begin n_fail++; $display("FAIL single_issue_ack: got %b expected 0000", bus.fu_ack_o); end
    tick();
    bus.issue_valid_i = 0;
    #1;
    n_tests++; if (bus.fu_ack_o !== 4'b0010) begin n_fail++; $display("FAIL single_ack: got %b expected 0010", bus.fu_ack_o); end
    tick();
    bus.fu_done_i = '0;
    #1;
    n_tests++; if (bus.ex_valid_o !== 1'b1 || bus.ex_r_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_result: got v=%b r=%h expected 1/deadbeef", bus.ex_valid_o, bus.ex_r_o); end
    n_tests++; if (bus.occupancy_o !== 3'd0) begin n_fail++; $display("FAIL single_occ: got %0d expected 0", bus.occupancy_o); end
    tick();
  endtask

  task automatic test_order();
    bus.issue_valid_i = 1; bus.issue_fu_i = 2'd3;
    tick();
    bus.issue_fu_i = 2'd0; bus.fu_done_i = 4'b0001; set_r(0, 32'h11); set_r(3, 32'h33);
    tick();
    bus.issue_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus.fu_ack_o !== 4'b0000 || bus.occupancy_o !== 3'd2) begin n_fail++; $display("FAIL order_wait%0d: got ack=%b occ=%0d expected 0000/2", i, bus.fu_ack_o, bus.occupancy_o); end
      tick();
    end
    bus.fu_done_i = 4'b1001;
    #1;
    n_tests++; if (bus.fu_ack_o !== 4'b1000) begin n_fail++; $display("FAIL order_ack3: got %b expected 1000", bus.fu_ack_o); end
    tick();
    bus.fu_done_i = 4'b0001;
    #1;
    n_tests++; if (bus.ex_valid_o !== 1'b1 || bus.ex_r_o !== 32'h33) begin n_fail++; $display("FAIL order_r33: got v=%b r=%h expected 1/33", bus.ex_valid_o, bus.ex_r_o); end
    n_tests++; if (bus.fu_ack_o !== 4'b0001) begin n_fail++; $display("FAIL order_ack0: got %b expected 0001", bus.fu_ack_o); end
    tick();
    bus.fu_done_i = '0;
    #1;
    n_tests++; if (bus.ex_valid_o !== 1'b1 || bus.ex_r_o !== 32'h11) begin n_fail++; $display("FAIL order_r11: got v=%b r=%h expected 1/11", bus.ex_valid_o, bus.ex_r_o); end
    tick();
    n_tests++; if (bus.ex_valid_o !== 1'b0 || bus.ex_r_o !== 32'h11) begin n_fail++; $display("FAIL order_idle: got v=%b r=%h expected 0/11", bus.ex_valid_o, bus.ex_r_o); end
  endtask

  task automatic test_full();
    int budget;
    for (int round = 0; round < 3; round++) begin
      bus.fu_done_i = '0;
      for (int i = 0; i < 4; i++) begin
        bus.issue_valid_i = 1; bus.issue_fu_i = 2'($urandom_range(0, 3));
        tick();
      end
      #1;
      n_tests++; if (bus.occupancy_o !== 3'd4 || bus.issue_ready_o !== 1'b0 || bus.ex_stall_o !== 1'b1) begin n_fail++; $display("FAIL full_flags%0d: got occ=%0d ready=%b stall=%b expected 4/0/1", round, bus.occupancy_o, bus.issue_ready_o, bus.ex_stall_o); end
      tick();
      n_tests++; if (bus.occupancy_o !== 3'd4) begin n_fail++; $display("FAIL full_no_push%0d: got %0d expected 4", round, bus.occupancy_o); end
      for (int k = 0; k < 4; k++) set_r(k, $urandom);
      bus.fu_done_i = N_FU'(1) << mq[0];
      #1;
      n_tests++; if (bus.fu_ack_o !== (N_FU'(1) << mq[0])) begin n_fail++; $display("FAIL full_pop_ack%0d: got %b expected %b", round, bus.fu_ack_o, N_FU'(1) << mq[0]); end
      tick();
      bus.fu_done_i = '0;
      #1;
      n_tests++; if (bus.occupancy_o !== 3'd3 || bus.issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_after_pop%0d: got occ=%0d ready=%b expected 3/1", round, bus.occupancy_o, bus.issue_ready_o); end
      tick();
      bus.issue_valid_i = 0;
      #1;
      n_tests++; if (bus.occupancy_o !== 3'd4) begin n_fail++; $display("FAIL full_refill%0d: got %0d expected 4", round, bus.occupancy_o); end
      bus.fu_done_i = 4'b1111;
      budget = 0;
      while (mq.size() != 0 && budget < 10) begin
        for (int k = 0; k < 4; k++) set_r(k, $urandom);
        tick();
        budget++;
        if (m_valid) begin
          n_tests++; if (bus.ex_valid_o !== 1'b1 || bus.ex_r_o !== m_r) begin n_fail++; $display("FAIL full_drain%0d: got v=%b r=%h expected 1/%h", round, bus.ex_valid_o, bus.ex_r_o, m_r); end
        end
      end
      n_tests++; if (bus.occupancy_o !== 3'd0 || mq.size() != 0) begin n_fail++; $display("FAIL full_drain_done%0d: got occ=%0d expected 0", round, bus.occupancy_o); end
    end
    bus.fu_done_i = '0;
    tick();
  endtask

  task automatic test_stall();
    logic            v0;
    logic [XLEN-1:0] r0;
    bus.issue_valid_i = 1; bus.issue_fu_i = 2'd2;
    tick();
    bus.issue_valid_i = 0; bus.fu_done_i = 4'b0100; set_r(2, 32'hAAAA5555); bus.mem_stall_i = 1;
    v0 = bus.ex_valid_o; r0 = bus.ex_r_o;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++; if (bus.fu_ack_o !== 4'b0000 || bus.ex_stall_o !== 1'b1) begin n_fail++; $display("FAIL stall_ack%0d: got ack=%b stall=%b expected 0000/1", i, bus.fu_ack_o, bus.ex_stall_o); end
      tick();
      n_tests++; if (bus.ex_valid_o !== v0 || bus.ex_r_o !== r0) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b r=%h expected %b/%h", i, bus.ex_valid_o, bus.ex_r_o, v0, r0); end
    end
    bus.mem_stall_i = 0;
    #1;
    n_tests++; if (bus.fu_ack_o !== 4'b0100) begin n_fail++; $display("FAIL stall_release_ack: got %b expected 0100", bus.fu_ack_o); end
    tick();
    bus.fu_done_i = '0; bus.mem_stall_i = 1;
    #1;
    n_tests++; if (bus.ex_valid_o !== 1'b1 || bus.ex_r_o !== 32'hAAAA5555) begin n_fail++; $display("FAIL stall_result: got v=%b r=%h expected 1/aaaa5555", bus.ex_valid_o, bus.ex_r_o); end
    tick();
    n_tests++; if (bus.ex_valid_o !== 1'b1 || bus.ex_r_o !== 32'hAAAA5555) begin n_fail++; $display("FAIL stall_keep_valid: got v=%b r=%h expected 1/aaaa5555", bus.ex_valid_o, bus.ex_r_o); end
    bus.mem_stall_i = 0;
    tick();
  endtask

  task automatic test_flush();
    logic [XLEN-1:0] r0;
    for (int i = 0; i < 3; i++) begin
      bus.issue_valid_i = 1; bus.issue_fu_i = 2'(i);
      tick();
    end
    r0 = bus.ex_r_o;
    bus.flush_i = 1; bus.issue_fu_i = 2'd3; bus.fu_done_i = 4'b0001; set_r(0, 32'h0BAD0BAD);
    #1;
    n_tests++; if (bus.fu_ack_o !== 4'b0000 || bus.occupancy_o !== 3'd3) begin n_fail++; $display("FAIL flush_ack: got ack=%b occ=%0d expected 0000/3", bus.fu_ack_o, bus.occupancy_o); end
    tick();
    bus.flush_i = 0; bus.issue_valid_i = 0; bus.fu_done_i = '0;
    #1;
    n_tests++; if (bus.occupancy_o !== 3'd0 || bus.ex_valid_o !== 1'b0 || bus.ex_r_o !== r0) begin n_fail++; $display("FAIL flush_clear: got occ=%0d v=%b r=%h expected 0/0/%h", bus.occupancy_o, bus.ex_valid_o, bus.ex_r_o, r0); end
    tick();
  endtask

  task automatic test_illegal();
    bus5.issue_valid_i = 1; bus5.issue_fu_i = 3'd5;
    tick();
    bus5.issue_valid_i = 0;
    #1;
    n_tests++; if (bus5.illegal_o !== 1'b1 || bus5.occupancy_o !== 3'd0) begin n_fail++; $display("FAIL illegal_set: got ill=%b occ=%0d expected 1/0", bus5.illegal_o, bus5.occupancy_o); end
    n_tests++; if (bus.illegal_o !== m_ill) begin n_fail++; $display("FAIL illegal_main: got %b expected %b", bus.illegal_o, m_ill); end
    bus5.flush_i = 1;
    tick();
    bus5.flush_i = 0;
    tick();
    n_tests++; if (bus5.illegal_o !== 1'b1) begin n_fail++; $display("FAIL illegal_after_flush: got %b expected 1", bus5.illegal_o); end
    // Leave a done head pending on the main queue, then reset asynchronously.
    bus.issue_valid_i = 1; bus.issue_fu_i = 2'd1;
    tick();
    bus.issue_valid_i = 0; bus.fu_done_i = 4'b0010; bus.mem_stall_i = 0;
    #1;
    n_tests++; if (bus.fu_ack_o !== 4'b0010) begin n_fail++; $display("FAIL prereset_ack: got %b expected 0010", bus.fu_ack_o); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.fu_ack_o !== 4'b0000 || bus.occupancy_o !== 3'd0) begin n_fail++; $display("FAIL async_reset: got ack=%b occ=%0d expected 0000/0", bus.fu_ack_o, bus.occupancy_o); end
    n_tests++; if (bus5.illegal_o !== 1'b0) begin n_fail++; $display("FAIL illegal_cleared: got %b expected 0", bus5.illegal_o); end
    do_reset();
  endtask

  task automatic test_random();
    logic [N_FU-1:0] ea;
    for (int c = 0; c < 600; c++) begin
      bus.issue_valid_i = ($urandom_range(0, 99) < 60);
      bus.issue_fu_i    = 2'($urandom_range(0, 3));
      bus.fu_done_i     = 4'($urandom);
      for (int k = 0; k < 4; k++) set_r(k, $urandom);
      bus.mem_stall_i   = ($urandom_range(0, 99) < 25);
      bus.flush_i       = ($urandom_range(0, 99) < 3);
      #1;
      ea = m_ack();
      n_tests++; if (bus.fu_ack_o !== ea) begin n_fail++; $display("FAIL rnd_ack@%0d: got %b expected %b", c, bus.fu_ack_o, ea); end
      n_tests++; if (bus.occupancy_o !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_occ@%0d: got %0d expected %0d", c, bus.occupancy_o, mq.size()); end
      n_tests++; if (bus.issue_ready_o !== (mq.size() < DEPTH) || bus.ex_stall_o !== (bus.mem_stall_i || mq.size() >= DEPTH)) begin n_fail++; $display("FAIL rnd_ready@%0d: got ready=%b stall=%b size=%0d", c, bus.issue_ready_o, bus.ex_stall_o, mq.size()); end
      n_tests++; if (bus.ex_valid_o !== m_valid || bus.ex_r_o !== m_r) begin n_fail++; $display("FAIL rnd_result@%0d: got v=%b r=%h expected %b/%h", c, bus.ex_valid_o, bus.ex_r_o, m_valid, m_r); end
      n_tests++; if (bus.illegal_o !== m_ill) begin n_fail++; $display("FAIL rnd_illegal@%0d: got %b expected %b", c, bus.illegal_o, m_ill); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_order();
    test_full();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
